// File: rtl/if_axi_fetch.sv
// if_axi_fetch: single-beat AXI4 instruction fetch master, one outstanding read, 32-bit inst out of 64-bit beat
module if_axi_fetch #(
  parameter logic [2:0] PROT_INST = 3'b100,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic        flush,
  output logic        ar_valid,
  input  logic        ar_ready,
  output logic [63:0] ar_addr,
  output logic [3:0]  ar_id,
  output logic [7:0]  ar_len,
  output logic [2:0]  ar_size,
  output logic [1:0]  ar_burst,
  output logic [2:0]  ar_prot,
  input  logic        r_valid,
  output logic        r_ready,
  input  logic [63:0] r_data,
  input  logic [1:0]  r_resp,
  input  logic        r_last,
  input  logic [3:0]  r_id,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_addr,
  output logic        inst_err
);
  localparam logic [31:0] NOP = 32'h00000013;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DROP} state_t;
  state_t state;
  logic [63:0] addr_q;
  logic flush_pend;
  assign ar_valid = state == ADDR;
  assign r_ready = state == DATA || state == DROP;
  assign ar_addr = {addr_q[63:3], 3'b000};
  assign ar_id = AXI_ID;
  assign ar_len = 8'd0;
  assign ar_size = 3'b011;
  assign ar_burst = 2'b01;
  assign ar_prot = PROT_INST;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      flush_pend <= 1'b0;
      inst_valid <= 1'b0;
      inst <= NOP;
      inst_addr <= '0;
      inst_err <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      case (state)
        IDLE: begin
          flush_pend <= 1'b0;
          if (req_valid && !flush) begin
            addr_q <= req_addr;
            if (req_addr[1:0] != 2'b00) begin
              inst_valid <= 1'b1;
              inst_err <= 1'b1;
              inst <= NOP;
              inst_addr <= req_addr;
            end else begin
              state <= ADDR;
            end
          end
        end
        ADDR: begin
          if (ar_ready) begin
            state <= (flush || flush_pend) ? DROP : DATA;
            flush_pend <= 1'b0;
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        DATA: begin
          if (r_valid) begin
            state <= IDLE;
            if (!flush) begin
              inst_valid <= 1'b1;
              inst_err <= r_resp != 2'b00;
              inst <= r_resp != 2'b00 ? NOP : (addr_q[2] ? r_data[63:32] : r_data[31:0]);
              inst_addr <= addr_q;
            end
          end else if (flush) begin
            state <= DROP;
          end
        end
        default: state <= r_valid ? IDLE : DROP;
      endcase
    end
  end
  a_rbeat: assert property (@(posedge clk) disable iff (rst) (r_valid && r_ready) |-> (r_id == AXI_ID && r_last));
endmodule

// File: tb/tb_if_axi_fetch.sv
// tb_if_axi_fetch: randomized fetch transactions checked cycle by cycle against a timeline model
module tb_if_axi_fetch;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 1'b0;
  logic rst, req_valid, flush, ar_ready, r_valid, r_last;
  logic [63:0] req_addr, r_data;
  logic [1:0] r_resp;
  logic [3:0] r_id;
  logic ar_valid, r_ready, inst_valid, inst_err;
  logic [63:0] ar_addr, inst_addr;
  logic [3:0] ar_id;
  logic [7:0] ar_len;
  logic [2:0] ar_size, ar_prot;
  logic [1:0] ar_burst;
  logic [31:0] inst;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] h_inst = NOP;
  logic [63:0] h_addr = '0;
  logic h_err = 1'b0;
  if_axi_fetch dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst), .ar_prot(ar_prot),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_id(r_id),
    .inst_valid(inst_valid), .inst(inst), .inst_addr(inst_addr), .inst_err(inst_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_outs(input logic av, input logic rr, input logic iv);
    chk("ar_valid", ar_valid, av);
    chk("r_ready", r_ready, rr);
    chk("inst_valid", inst_valid, iv);
    chk("inst", inst, h_inst);
    chk("inst_err", inst_err, h_err);
    chk("inst_addr", inst_addr, h_addr);
  endtask
  // f: -1 no flush, 0 flush with the request, k>0 flush k cycles after the request
  task automatic fetch(input logic [63:0] a, input logic [63:0] d, input logic [1:0] resp,
                       input int aw, input int rw, input int f);
    logic mis, go, bus, av, rr, iv;
    int n;
    mis = a[1:0] != 2'b00;
    go = f != 0;
    bus = go && !mis;
    n = bus ? 3 + aw + rw : 1;
    req_valid = 1'b1;
    req_addr = a;
    flush = f == 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      av = bus && c <= 1 + aw;
      rr = bus && c >= 2 + aw && c <= 2 + aw + rw;
      iv = go && c == n && (mis || f < 1);
      if (iv) begin
        h_err = mis || resp != 2'b00;
        h_inst = h_err ? NOP : (a[2] ? d[63:32] : d[31:0]);
        h_addr = a;
      end
      chk_outs(av, rr, iv);
      if (av) chk("ar_addr", ar_addr, {a[63:3], 3'b000});
      req_valid = 1'b0;
      flush = c == f;
      ar_ready = bus && c == 1 + aw;
      r_valid = bus && c == 2 + aw + rw;
      r_data = d;
      r_resp = resp;
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [63:0] a;
    int aw, rw, f;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0; ar_ready = 1'b0;
    r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b1; r_id = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_outs(1'b0, 1'b0, 1'b0);
    chk("ar_const", {ar_id, ar_len, ar_size, ar_burst, ar_prot}, {4'd0, 8'd0, 3'b011, 2'b01, 3'b100});
    fetch(64'h8000_0004, 64'h00A00513_00000297, 2'b00, 0, 0, -1);
    fetch(64'h8000_0000, 64'h00A00513_00000297, 2'b00, 2, 3, -1);
    fetch(64'h8000_0008, 64'h11111111_22222222, 2'b00, 3, 1, 1);
    fetch(64'h8000_0100, 64'h33333333_44444444, 2'b00, 0, 0, -1);
    fetch(64'h8000_0104, 64'h55555555_66666666, 2'b00, 0, 2, 3);
    fetch(64'h8000_0110, 64'h77777777_88888888, 2'b10, 1, 1, -1);
    fetch(64'h8000_0002, 64'h0, 2'b00, 0, 0, -1);
    fetch(64'h8000_0200, 64'h0, 2'b00, 0, 0, 0);
    fetch(64'h8000_0204, 64'h99999999_aaaaaaaa, 2'b00, 1, 0, 2);
    req_valid = 1'b1;
    req_addr = 64'h8000_0300;
    @(negedge clk);
    req_valid = 1'b0;
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    h_inst = NOP; h_err = 1'b0; h_addr = '0;
    chk_outs(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      a = {$urandom, $urandom};
      a[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      aw = $urandom_range(0, 3);
      rw = $urandom_range(0, 3);
      f = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, 2 + aw + rw);
      fetch(a, {$urandom, $urandom}, ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, aw, rw, f);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk_outs(1'b0, 1'b0, 1'b0);
      end
    end
    @(negedge clk);
    chk_outs(1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/if_axi_fetch.md
# if_axi_fetch

Instruction-fetch bus master of the AXI CPU front end. It takes the next instruction address computed by the fetch stage and runs one single-beat AXI4 read per instruction. It extracts the 32-bit instruction from the 64-bit read beat and pulses `inst_valid` for one cycle. That pulse is the enable that advances the PC register and launches the instruction into decode.

## Interface
- `PROT_INST`, 3'b100: value driven on `ar_prot` (instruction access).
- `AXI_ID`, 4'd0: value driven on `ar_id`; expected on `r_id`.
- `clk`  in  1  clock; reset `rst`, synchronous, active-high.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  fetch requested for `req_addr`; level, sampled in IDLE only.
- `req_addr`  in  64  next instruction address (the PC's next value).
- `flush`  in  1  redirect; discard any in-flight fetch.
- `ar_valid`  out  1  AXI read-address valid.
- `ar_ready`  in  1  AXI read-address ready.
- `ar_addr`  out  64  `{addr_q[63:3], 3'b000}`.
- `ar_id`  out  4  `AXI_ID`.
- `ar_len`  out  8  constant 8'd0.
- `ar_size`  out  3  constant 3'b011.
- `ar_burst`  out  2  constant 2'b01.
- `ar_prot`  out  3  `PROT_INST`.
- `r_valid`  in  1  AXI read-data valid.
- `r_ready`  out  1  AXI read-data ready.
- `r_data`  in  64  read beat.
- `r_resp`  in  2  read response.
- `r_last`  in  1  last beat; always 1 for len 0.
- `r_id`  in  4  read ID.
- `inst_valid`  out  1  one-cycle pulse: `inst`/`inst_addr`/`inst_err` are new.
- `inst`  out  32  fetched instruction.
- `inst_addr`  out  64  address of `inst`.
- `inst_err`  out  1  misaligned address or bus error.

## Operation
- States:
  - IDLE (reset state)
  - ADDR: `ar_valid`=1
  - DATA: `r_ready`=1
  - DROP: `r_ready`=1, response is discarded
- IDLE:
  - If `req_valid` and not `flush`, register `addr_q`=`req_addr`.
  - If `req_addr[1:0]`!=0, no bus transaction. Next cycle `inst_valid`=1, `inst_err`=1, `inst`=32'h00000013, `inst_addr`=`req_addr`. Stay in IDLE.
  - Otherwise go to ADDR.
- ADDR:
  - Hold `ar_valid` and `ar_addr` stable until `ar_ready`. The AXI rule forbids withdrawing the request.
  - On handshake, go to DATA; if `flush` is seen in the same cycle or was seen earlier in ADDR, go to DROP instead.
  - A `flush` arriving in ADDR is remembered in `flush_pend`.
- DATA, on `r_valid`:
  - `inst` = `addr_q[2]` ? `r_data[63:32]` : `r_data[31:0]`.
  - `inst_err` = (`r_resp`!=2'b00).
  - If `inst_err`, `inst` is forced to 32'h00000013.
  - `inst_addr`=`addr_q`, `inst_valid` pulses, go to IDLE.
  - `flush` with or before `r_valid`: DATA→DROP, or IDLE directly if `r_valid` is in the same cycle. No `inst_valid` is produced.
- DROP: accept one beat (`r_valid`), produce no outputs, go to IDLE.
- `flush` in IDLE: ignore `req_valid` that cycle.
- `r_id`≠`AXI_ID` or `r_last`=0: no functional effect (single outstanding read). Simulation assertion only.
- Only one outstanding transaction ever.
- `inst`, `inst_addr`, `inst_err` hold their value between pulses.

## Timing
- Reset values:
  - state IDLE
  - `ar_valid`=0, `r_ready`=0, `inst_valid`=0
  - `inst`=32'h00000013, `inst_addr`=0, `inst_err`=0
  - `flush_pend`=0
- `ar_valid` and `r_ready` are decoded from the registered state, so they are glitch-free. All other outputs are registered.
- Best case, request sampled in cycle 0:
  - `ar_valid` cycle 1, with `ar_ready` in cycle 1
  - `r_valid` cycle 2
  - `inst_valid` cycle 3
- Each `ar_ready` or `r_valid` wait cycle adds one cycle of latency.
- Back-to-back requests: the next request is sampled in the cycle `inst_valid` is high (state IDLE). Peak throughput is 1 instruction per 3 cycles.
- Misaligned request: `inst_valid` one cycle after sampling.
- `rst` mid-transaction returns to IDLE immediately; the outstanding beat is not tracked. The system resets the interconnect together with the core.

## Test plan
- Aligned fetch: `req_addr`=64'h8000_0004, `r_data`=64'h00A00513_00000297, zero-wait slave. Expect `ar_addr`=64'h8000_0000; `inst_valid` 3 cycles after request; `inst`=32'h00A00513; `inst_err`=0.
- Wait states: `ar_ready` delayed 2 cycles, `r_valid` delayed 3 cycles. Expect `ar_valid` and `ar_addr` stable throughout; exactly one `inst_valid`, 8 cycles after request; no second AR issued.
- Flush in ADDR: `flush` while `ar_ready`=0. Expect `ar_valid` held until handshake, then DROP; beat consumed; no `inst_valid`. A next request to 64'h8000_0100 yields its own instruction.
- Flush in DATA: `flush` one cycle before `r_valid`. Expect no `inst_valid`; state back in IDLE the cycle after the beat.
- Errors: `r_resp`=2'b10 gives `inst_valid`, `inst_err`=1, `inst`=32'h00000013. `req_addr`=64'h8000_0002 gives `inst_err`=1, no `ar_valid`, `inst_valid` one cycle later.
- Reset mid-DATA: `rst` high one cycle. Expect `ar_valid`=0, `r_ready`=0, `inst_valid`=0, `inst`=32'h00000013, `inst_addr`=0 the following cycle.
